// File: rtl/patcnt_pkg.sv
// Shared types and helpers for the pattern-count engine.
// Holds the run-state encoding and the count-width derivation.
package patcnt_pkg;

    localparam int BITS_PER_BYTE = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Widest count is the stream count, bounded by the total number of message bits.
    function automatic int cnt_width(input int msg_bytes);
        return $clog2(BITS_PER_BYTE * msg_bytes + 1);
    endfunction

endpackage

// File: rtl/pat_window_match.sv
// Combinational window matcher over {history, byte}; zero latency, no flow control.
// Bit j of stream_hit is the window ending on byte bit j; in-byte windows are its low 9-PAT_W bits.
module pat_window_match
    import patcnt_pkg::*;
#(
    parameter int PAT_W = 5
) (
    input  logic [PAT_W+BITS_PER_BYTE-2:0] win,
    input  logic [PAT_W-1:0]               pat,
    input  logic [PAT_W-1:0]               mask,
    output logic [BITS_PER_BYTE-1:0]       stream_hit,
    output logic [BITS_PER_BYTE-PAT_W:0]   byte_hit,
    output logic [3:0]                     stream_cnt,
    output logic [3:0]                     byte_cnt
);

    always_comb begin
        stream_hit = '0;
        for (int j = 0; j < BITS_PER_BYTE; j++) begin
            // A set mask bit makes that pattern position a don't-care.
            stream_hit[j] = &((~(win[j +: PAT_W] ^ pat)) | mask);
        end
    end

    always_comb begin
        byte_hit = '0;
        for (int k = 0; k <= BITS_PER_BYTE - PAT_W; k++) begin
            byte_hit[k] = stream_hit[k];
        end
    end

    always_comb begin
        stream_cnt = '0;
        for (int j = 0; j < BITS_PER_BYTE; j++) begin
            stream_cnt = stream_cnt + {3'b000, stream_hit[j]};
        end
    end

    always_comb begin
        byte_cnt = '0;
        for (int k = 0; k <= BITS_PER_BYTE - PAT_W; k++) begin
            byte_cnt = byte_cnt + {3'b000, byte_hit[k]};
        end
    end

endmodule

// File: rtl/pattern_count_engine.sv
// Streaming pattern counter (in-byte, bytes-hit, bit-stream); define PATCNT_MASK_EN for a don't-care mask port.
// Counts visible one cycle after each accept; byte_ready is high only in RUN, gaps in byte_valid are legal.
module pattern_count_engine
    import patcnt_pkg::*;
#(
    parameter int PAT_W     = 5,
    parameter int MSG_BYTES = 32,
    parameter int CNT_W     = cnt_width(MSG_BYTES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pat_in,
`ifdef PATCNT_MASK_EN
    input  logic [PAT_W-1:0] pat_mask,
`endif
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cnt_in_byte,
    output logic [CNT_W-1:0] cnt_bytes_hit,
    output logic [CNT_W-1:0] cnt_stream
);

    localparam int IDX_W = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [PAT_W-2:0]   hist_q, hist_d;
    logic [CNT_W-1:0]   cnt_in_byte_q, cnt_in_byte_d;
    logic [CNT_W-1:0]   cnt_bytes_hit_q, cnt_bytes_hit_d;
    logic [CNT_W-1:0]   cnt_stream_q, cnt_stream_d;
    logic [PAT_W-1:0]   mask_eff;

    logic [BITS_PER_BYTE-1:0]     stream_hit_unused;
    logic [BITS_PER_BYTE-PAT_W:0] byte_hit;
    logic [3:0]                   stream_cnt;
    logic [3:0]                   byte_cnt;
    logic [3:0]                   stream_add;
    logic                         accept;

`ifdef PATCNT_MASK_EN
    logic [PAT_W-1:0] mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        if (start) begin
            mask_d = pat_mask;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign mask_eff = mask_q;
`else
    assign mask_eff = '0;
`endif

    pat_window_match #(
        .PAT_W (PAT_W)
    ) u_match (
        .win        ({hist_q, byte_data}),
        .pat        (pat_q),
        .mask       (mask_eff),
        .stream_hit (stream_hit_unused),
        .byte_hit   (byte_hit),
        .stream_cnt (stream_cnt),
        .byte_cnt   (byte_cnt)
    );

    // A start in the same cycle as a presented byte wins; that byte is dropped.
    assign accept = byte_valid && (state_q == RUN) && !start;

    // The first byte has no meaningful history, so only its in-byte windows count.
    assign stream_add = (idx_q == '0) ? byte_cnt : stream_cnt;

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        pat_d           = pat_q;
        hist_d          = hist_q;
        cnt_in_byte_d   = cnt_in_byte_q;
        cnt_bytes_hit_d = cnt_bytes_hit_q;
        cnt_stream_d    = cnt_stream_q;
        if (start) begin
            state_d         = RUN;
            idx_d           = '0;
            pat_d           = pat_in;
            cnt_in_byte_d   = '0;
            cnt_bytes_hit_d = '0;
            cnt_stream_d    = '0;
        end else if (accept) begin
            cnt_in_byte_d   = cnt_in_byte_q + CNT_W'(byte_cnt);
            cnt_bytes_hit_d = cnt_bytes_hit_q + CNT_W'(|byte_hit);
            cnt_stream_d    = cnt_stream_q + CNT_W'(stream_add);
            hist_d          = byte_data[PAT_W-2:0];
            if (idx_q == LAST_IDX) begin
                state_d = DONE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            pat_q           <= '0;
            hist_q          <= '0;
            cnt_in_byte_q   <= '0;
            cnt_bytes_hit_q <= '0;
            cnt_stream_q    <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            pat_q           <= pat_d;
            hist_q          <= hist_d;
            cnt_in_byte_q   <= cnt_in_byte_d;
            cnt_bytes_hit_q <= cnt_bytes_hit_d;
            cnt_stream_q    <= cnt_stream_d;
        end
    end

    assign byte_ready    = (state_q == RUN);
    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign cnt_in_byte   = cnt_in_byte_q;
    assign cnt_bytes_hit = cnt_bytes_hit_q;
    assign cnt_stream    = cnt_stream_q;

endmodule

// File: doc/pattern_count_engine.md
Name: pattern_count_engine

Overview:
- Streaming pattern-search accelerator for the program-3 workload, generalised in pattern width and message length.
- After a start pulse, it accepts MSG_BYTES message bytes, one per handshake, and compares each against a PAT_W-bit pattern.
- It produces three counts: matches inside a byte, bytes with at least one match, and matches anywhere in the bit stream including across byte boundaries.
- It sits beside the datapath; the controller streams data-memory bytes in and writes the counts back to memory.

Parameters:
- PAT_W, 5, pattern width in bits; legal range 2..8.
- MSG_BYTES, 32, number of message bytes per run; must be at least 1.
- CNT_W, $clog2(8*MSG_BYTES+1), width of every count output; derived, do not override.

Ports:
- clk  in  1  clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; latches pat_in, clears counts, begins a run.
- pat_in  in  PAT_W  pattern to search for; sampled only on start.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  message byte; byte 0 first; bit 7 is the earliest bit in the stream.
- byte_ready  out  1  high in RUN; a byte is accepted when byte_valid and byte_ready are both high.
- busy  out  1  high in RUN.
- done  out  1  high in DONE; held until the next start.
- cnt_in_byte  out  CNT_W  matches fully inside a byte, summed over all bytes.
- cnt_bytes_hit  out  CNT_W  bytes containing at least one in-byte match.
- cnt_stream  out  CNT_W  matches anywhere in the concatenated bit stream.

Behaviour:
- Reset (async, reset low):
  - state goes to IDLE.
  - All counts go to 0; the pattern register goes to 0.
  - byte_ready, busy and done go to 0.
  - A reset during a run aborts the run; no partial counts survive.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE on the cycle the MSG_BYTES-th byte is accepted.
  - DONE -> RUN on start.
  - start while in RUN restarts the run: counts clear, the new pat_in is latched, the byte index returns to 0, and any byte presented in that same cycle is discarded.
- Per accepted byte (single cycle, no pipeline):
  - In-byte windows are byte_data[k+PAT_W-1:k] for k = 0..8-PAT_W, giving 9-PAT_W windows.
  - m = number of matching in-byte windows. cnt_in_byte += m; cnt_bytes_hit += 1 when m > 0.
  - A history register holds the previous PAT_W-1 stream bits.
  - Stream windows are those ending on each of the 8 new bits, formed over {history, byte_data}.
  - On byte 0, only windows lying wholly inside the byte are counted, so no history is used. Byte 0 therefore adds m to cnt_stream; every later byte adds up to 8.
  - History updates to byte_data[PAT_W-2:0] after each accept.
- Counts are registered and visible the cycle after the accept. done rises in that same cycle, with the final counts.
- Maximum values fit CNT_W without overflow; no saturation logic is required:
  - cnt_in_byte: (9-PAT_W)*MSG_BYTES.
  - cnt_bytes_hit: MSG_BYTES.
  - cnt_stream: 8*MSG_BYTES-PAT_W+1.
- byte_valid gaps are legal; state and counts hold while byte_valid is low.
- byte_valid in IDLE or DONE is ignored.
- Counts stay stable in DONE until the next start.

Optional Feature:
- Macro: PATCNT_MASK_EN.
- Defined:
  - Adds input port pat_mask [PAT_W-1:0], latched on start alongside pat_in.
  - A bit position matches when the data bit equals the pattern bit or pat_mask is 1 (don't-care).
  - An all-ones mask matches every window.
- Undefined: no pat_mask port exists; comparisons are exact.

Decomposition:
- Package patcnt_pkg:
  - state enum: IDLE, RUN, DONE.
  - Function cnt_width(msg_bytes).
  - Constant BITS_PER_BYTE = 8.
- Sub-module pat_window_match:
  - Purely combinational.
  - Inputs: a (PAT_W-1+8)-bit window, the pattern, and the mask.
  - Outputs: an 8-bit stream match vector and a (9-PAT_W)-bit in-byte match vector, each with popcounts.
- Top level holds the FSM, byte index, history register and accumulators.

Test Plan:
- PAT_W=5, pattern 10101, 32 bytes of 0x00 -> counts 0 / 0 / 0; done asserted one cycle after the 32nd accept.
- Pattern 10101, 32 bytes of 0x55 -> cnt_in_byte=64, cnt_bytes_hit=32, cnt_stream=126.
- Pattern 00000, 32 bytes of 0x00 -> counts 128 / 32 / 252 (maximum-value check).
- Pattern 11111; bytes 0x07, 0xC0, then 30 bytes of 0x00 -> counts 0 / 0 / 1 (single boundary-crossing match).
- 0x55 stream with byte_valid toggling every other cycle; a start pulse after byte 10 -> restart; final counts equal the clean 0x55 case (64 / 32 / 126).
- reset driven low mid-run after byte 5 -> all outputs 0 immediately; a fresh run then matches the expected counts.
- With PATCNT_MASK_EN: pattern 10101, mask 00100, bytes 0x51 repeated -> each window 10001 or 10101 matches.
